// File: rtl/fp_norm_pkg.sv
// Shared types and constants for the shared floating-point normalizer scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_norm_pkg;

  localparam int MANTW   = 24;  // mantissa width seen by the normalizer
  localparam int SAW     = 5;   // shift-count width
  localparam int SRCW    = 2;   // requester index width (up to 4 requesters)
  localparam int FP_EXPW = 8;   // exponent width carried in the result struct
  localparam int FP_TAGW = 4;   // tag width carried in the result struct

  // Shift count reported for an all-zero mantissa.
  localparam logic [SAW-1:0] SA_ZERO = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [MANTW-1:0]   mant;
    logic [FP_EXPW-1:0] exp;
    logic [FP_TAGW-1:0] tag;
    logic [SRCW-1:0]    src;
    logic               zero;
    logic               unf;
  } norm_result_t;

endpackage

// File: rtl/fp_norm_lzshift.sv
// Leading-one normalizer: shifts a 24-bit mantissa left until bit 23 is set.
// Latency: purely combinational.
// Backpressure: none; ports are mant_i (in), mant_o (normalized), sa_o (shift, 31 for zero).
module fp_norm_lzshift
  import fp_norm_pkg::*;
(
  input  logic [MANTW-1:0] mant_i,
  output logic [MANTW-1:0] mant_o,
  output logic [SAW-1:0]   sa_o
);

  logic found;

  // Priority scan from the MSB; the first set bit fixes the shift count.
  always_comb begin
    found = 1'b0;
    sa_o  = SA_ZERO;
    for (int i = MANTW - 1; i >= 0; i--) begin
      if (!found && mant_i[i]) begin
        found = 1'b1;
        sa_o  = SAW'(MANTW - 1 - i);
      end
    end
    mant_o = found ? (mant_i << sa_o) : '0;
  end

endmodule

// File: rtl/rr_arb_onehot.sv
// Round-robin picker: first asserted valid at or above ptr, wrapping around.
// Latency: purely combinational; pointer state lives in the parent.
// Backpressure: none; ports are valid/ptr (in), gnt one-hot, idx encoded, any (out).
module rr_arb_onehot
  import fp_norm_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] valid,
  input  logic [SRCW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [SRCW-1:0] idx,
  output logic            any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && valid[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = SRCW'(j);
      end
    end
  end

endmodule

// File: rtl/fp_norm_sched.sv
// Shares one leading-one normalizer among NREQ requesters via round-robin arbitration.
// Latency: accept edge N -> out_valid from edge N+1 (visible 2 cycles after accept); 1 result / 2 cycles.
// Backpressure: result held while out_ready=0 and req_ready forced low; ports are req_* (per requester) and out_* (result).
module fp_norm_sched
  import fp_norm_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int EXPW = FP_EXPW,
  parameter int TAGW = FP_TAGW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*MANTW-1:0] req_mant,
  input  logic [NREQ*EXPW-1:0]  req_exp,
  input  logic [NREQ*TAGW-1:0]  req_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MANTW-1:0]      out_mant,
  output logic [EXPW-1:0]       out_exp,
  output logic [TAGW-1:0]       out_tag,
  output logic [SRCW-1:0]       out_src,
  output logic                  out_zero,
  output logic                  out_unf
);

  state_e           state_q, state_d;
  logic [SRCW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [MANTW-1:0] op_mant_q, op_mant_d;
  logic [EXPW-1:0]  op_exp_q, op_exp_d;
  logic [TAGW-1:0]  op_tag_q, op_tag_d;
  logic [SRCW-1:0]  op_src_q, op_src_d;
  norm_result_t     res_q, res_d, calc_res;

  logic [NREQ-1:0]  arb_gnt;
  logic [SRCW-1:0]  arb_idx;
  logic             arb_any;
  logic             arb_en;
  logic             xfer;

  logic [MANTW-1:0] norm_mant;
  logic [SAW-1:0]   norm_sa;
  logic [EXPW:0]    exp_diff;
  logic             op_zero;
  logic             exp_gt;

  rr_arb_onehot #(.NREQ(NREQ)) u_arb (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  fp_norm_lzshift u_norm (
    .mant_i (op_mant_q),
    .mant_o (norm_mant),
    .sa_o   (norm_sa)
  );

  // Arbitration is open when idle, or when the held result is leaving this
  // cycle (back-to-back accept). rst_n gates it so grants drop during reset.
  assign arb_en    = rst_n && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign req_ready = arb_en ? arb_gnt : '0;
  assign xfer      = arb_en && arb_any;

  // Exponent adjust: one extra bit catches the borrow, so exp > sa exactly
  // when the difference is non-negative and non-zero.
  always_comb begin
    op_zero  = (op_mant_q == '0);
    exp_diff = {1'b0, op_exp_q} - (EXPW + 1)'(norm_sa);
    exp_gt   = !exp_diff[EXPW] && (exp_diff[EXPW-1:0] != '0);

    calc_res      = '0;
    calc_res.mant = norm_mant;
    calc_res.tag  = FP_TAGW'(op_tag_q);
    calc_res.src  = op_src_q;
    calc_res.zero = op_zero;
    calc_res.unf  = !op_zero && !exp_gt;
    calc_res.exp  = (!op_zero && exp_gt) ? FP_EXPW'(exp_diff[EXPW-1:0]) : '0;
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    op_mant_d = op_mant_q;
    op_exp_d  = op_exp_q;
    op_tag_d  = op_tag_q;
    op_src_d  = op_src_q;
    res_d     = res_q;

    case (state_q)
      S_IDLE: ;
      S_CALC: begin
        res_d   = calc_res;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A transfer (from idle or on the output handshake) overrides the above.
    if (xfer) begin
      op_mant_d = req_mant[int'(arb_idx)*MANTW +: MANTW];
      op_exp_d  = req_exp[int'(arb_idx)*EXPW +: EXPW];
      op_tag_d  = req_tag[int'(arb_idx)*TAGW +: TAGW];
      op_src_d  = arb_idx;
      rr_ptr_d  = (arb_idx == SRCW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
      state_d   = S_CALC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      op_mant_q <= '0;
      op_exp_q  <= '0;
      op_tag_q  <= '0;
      op_src_q  <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      op_mant_q <= op_mant_d;
      op_exp_q  <= op_exp_d;
      op_tag_q  <= op_tag_d;
      op_src_q  <= op_src_d;
      res_q     <= res_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign out_mant  = res_q.mant;
  assign out_exp   = EXPW'(res_q.exp);
  assign out_tag   = TAGW'(res_q.tag);
  assign out_src   = res_q.src;
  assign out_zero  = res_q.zero;
  assign out_unf   = res_q.unf;

endmodule
